// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder. A single full-adder cell and a carry flip-flop
// handle one bit per clock, LSB first. An operation runs from the accepting
// edge to the result edge WIDTH clocks later. One extra cycle in DONE then
// pulses `done`, which gives WIDTH+2 clocks per operation when start is held.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin an addition (sampled in IDLE only)
//   a, b   in   WIDTH  operands, captured when start is accepted
//   cin    in   1      carry-in, captured when start is accepted
//   s      out  WIDTH  registered sum of the last completed operation
//   cout   out  1      registered carry-out of the last completed operation
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse, s/cout were just updated
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    // The result shift register holds WIDTH-1 bits. The last sum bit goes
    // straight into s together with them on the final edge.
    logic [WIDTH-2:0] r_res;

    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_next;

    // Full-adder bit cell on the current LSBs and the stored carry.
    assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    // The new sum bit enters at the MSB, and the older bits move one place right.
    assign w_next  = {w_sum, r_res};

    // NOTE: sequential state uses non-blocking assignments, so every register
    // in this block samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register is reset here, including the datapath
            // shift registers. An aborted operation therefore leaves no trace.
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            s       <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry;
                    r_res   <= w_next[WIDTH-1:1];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // This edge processes the MSB, so the full result is ready now.
                    if (r_cnt == LAST_BIT) begin
                        s       <= w_next;
                        cout    <= w_carry;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder with WIDTH=8. Each accepted operation
// pushes its expected {cout,s} into a queue. A negedge monitor pops one entry
// per done pulse and compares it with the DUT outputs. Timing properties such
// as latency, busy length and back-to-back spacing are checked in the
// stimulus thread.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;
    logic             done;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int         n_vec        = 0;
    int         n_miscompare = 0;
    int         n_done       = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_miscompare++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    // Scoreboard monitor. It samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            check("busy_during_done", 32'(busy), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_v = sb.pop_front();
                check("sum", 32'({cout, s}), 32'(exp_v));
            end
        end
    end

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 9'(c);
    endfunction

    // Run one operation. Check the done latency and the busy length in cycles.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input string tag);
        int lat  = 0;
        int bcnt = 0;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        sb.push_back(model(ta, tb_v, tc));
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Scramble the inputs after capture. They must not affect the result.
                start = 1'b0;
                a     = 8'($urandom);
                b     = 8'($urandom);
                cin   = 1'($urandom);
            end
            if (busy) bcnt++;
            if (done && lat == 0) lat = i;
            if (!busy) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd9);
    endtask

    initial begin
        int         n_before;
        int         k;
        int         d[3];
        logic [7:0] ra, rb;
        logic       rc;

        // Asynchronous reset is active before any clock edge.
        #3;
        check("rst_s", 32'(s), 32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        #10 rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, "basic");
        check("basic_s_hold", 32'(s), 32'h10);
        run_op(8'hFF, 8'h01, 1'b0, "wrap1");
        run_op(8'hFF, 8'hFF, 1'b1, "wrap2");
        for (int i = 0; i < 5; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run_op(ra, rb, rc, "rand");
        end

        // A start pulse during RUN is ignored.
        n_before = n_done;
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        sb.push_back(model(8'h01, 8'h01, 1'b0));
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; a = 8'h55;
        @(negedge clk); start = 1'b0; a = 8'h00;
        repeat (15) @(negedge clk);
        check("busy_start_done_count", 32'(n_done - n_before), 32'd1);
        check("busy_start_s", 32'(s), 32'h02);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        sb.push_back(model(8'hFF, 8'hFF, 1'b0));
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_s", 32'(s), 32'h0);
        check("abort_cout", 32'(cout), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        void'(sb.pop_back());
        n_before = n_done;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(n_done - n_before), 32'd0);
        run_op(8'h2A, 8'h15, 1'b1, "after_reset");
        check("after_reset_s", 32'(s), 32'h40);
        check("after_reset_cout", 32'(cout), 32'h0);

        // Back-to-back operations with start held high.
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        for (int j = 0; j < 3; j++) sb.push_back(model(8'h03, 8'h04, 1'b0));
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                d[k] = i;
                k++;
                if (k == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        check("b2b_count", 32'(k), 32'd3);
        if (k == 3) begin
            check("b2b_first", 32'(d[0]), 32'd9);
            check("b2b_gap1", 32'(d[1] - d[0]), 32'd10);
            check("b2b_gap2", 32'(d[2] - d[1]), 32'd10);
        end
        repeat (15) @(negedge clk);
        check("end_idle_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
